multi_button_ctrl: RTL and testbench

//   Parametrised N-channel push-button front end; successor to the single-channel debouncer.
//   Per channel: 2-flop synchroniser, symmetric debounce, debounced level, 1-cycle press/release pulses,

---
 rtl/btn_ctrl_pkg.sv | 17 +
 rtl/button_channel.sv | 141 ++++++++++++++
 rtl/multi_button_ctrl.sv | 38 +++
 tb/tb_multi_button_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/btn_ctrl_pkg.sv
// Shared definitions for the multi-channel button front end.
// Channel FSM encoding and default 100 MHz timing constants.
package btn_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_WAIT = 2'd1,
    HELD       = 2'd2,
    REL_WAIT   = 2'd3
  } btn_state_t;

  localparam int DEF_NUM_BTN      = 4;
  localparam int DEF_DEBOUNCE_CYC = 500_000;
  localparam int DEF_LONG_CYC     = 100_000_000;
  localparam int DEF_CNT_W        = 32;

endpackage

// File: rtl/button_channel.sv
// One button: 2-flop sync, symmetric debounce FSM, press/release pulses.
// Long-press pulse present only when BTN_LONG_PRESS_EN is defined.
module button_channel
  import btn_ctrl_pkg::*;
#(
  parameter logic PUSHED_LVL   = 1'b1,
  parameter int   DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int   LONG_CYC     = DEF_LONG_CYC,
  parameter int   CNT_W        = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic button,
  output logic level,
  output logic press,
  output logic rel,
  output logic long_hit
);

  localparam logic [CNT_W-1:0] ONE =
    CNT_W'(1);
  localparam logic [CNT_W-1:0] DEB_LAST =
    CNT_W'(DEBOUNCE_CYC - 1);

  if (DEBOUNCE_CYC < 2 || LONG_CYC < 1) begin : g_bad_cfg
    $error("button_channel: bad timing parameters");
  end

  logic             s1;
  logic             s2;
  logic             p;
  btn_state_t       state;
  logic [CNT_W-1:0] cnt;

  // Bring the raw pin into the clock domain; idle as released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= ~PUSHED_LVL;
      s2 <= ~PUSHED_LVL;
    end else begin
      s1 <= button;
      s2 <= s1;
    end
  end

  assign p = (s2 == PUSHED_LVL);

  // Debounce FSM: a change is accepted after DEBOUNCE_CYC agreeing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
      rel   <= 1'b0;
    end else begin
      press <= 1'b0;
      rel   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (p) begin
            state <= PRESS_WAIT;
            cnt   <= ONE;
          end
        end
        PRESS_WAIT: begin
          if (!p) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == DEB_LAST) begin
            state <= HELD;
            press <= 1'b1;
            level <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        HELD: begin
          if (!p) begin
            state <= REL_WAIT;
            cnt   <= ONE;
          end
        end
        REL_WAIT: begin
          if (p) begin
            state <= HELD;
            cnt   <= '0;
          end else if (cnt == DEB_LAST) begin
            state <= IDLE;
            rel   <= 1'b1;
            level <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef BTN_LONG_PRESS_EN
  localparam logic [CNT_W-1:0] LONG_LAST =
    CNT_W'(LONG_CYC - 1);

  logic [CNT_W-1:0] hold_cnt;
  logic             long_done;

  // Time the hold; one long pulse per accepted press, bounce restarts timing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt  <= '0;
      long_done <= 1'b0;
      long_hit  <= 1'b0;
    end else begin
      long_hit <= 1'b0;
      if (state == PRESS_WAIT && p
          && cnt == DEB_LAST) begin
        hold_cnt  <= '0;
        long_done <= 1'b0;
      end else if (state == REL_WAIT && p) begin
        hold_cnt <= '0;
      end else if (state == HELD && p) begin
        if (hold_cnt != LONG_LAST) begin
          hold_cnt <= hold_cnt + ONE;
        end else if (!long_done) begin
          long_hit  <= 1'b1;
          long_done <= 1'b1;
        end
      end
    end
  end
`else
  assign long_hit = 1'b0;
`endif

endmodule

// File: rtl/multi_button_ctrl.sv
// N independent debounced button channels with press/release/long pulses.
// Long-press pulses enabled by defining BTN_LONG_PRESS_EN.
module multi_button_ctrl
  import btn_ctrl_pkg::*;
#(
  parameter int   NUM_BTN      = DEF_NUM_BTN,
  parameter logic PUSHED_LVL   = 1'b1,
  parameter int   DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int   LONG_CYC     = DEF_LONG_CYC,
  parameter int   CNT_W        = DEF_CNT_W
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic [NUM_BTN-1:0] i_button,
  output logic [NUM_BTN-1:0] o_level,
  output logic [NUM_BTN-1:0] o_press,
  output logic [NUM_BTN-1:0] o_release,
  output logic [NUM_BTN-1:0] o_long
);

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
    button_channel #(
      .PUSHED_LVL  (PUSHED_LVL),
      .DEBOUNCE_CYC(DEBOUNCE_CYC),
      .LONG_CYC    (LONG_CYC),
      .CNT_W       (CNT_W)
    ) u_ch (
      .clk     (i_clk),
      .rst_n   (i_reset_n),
      .button  (i_button[g]),
      .level   (o_level[g]),
      .press   (o_press[g]),
      .rel     (o_release[g]),
      .long_hit(o_long[g])
    );
  end

endmodule

// File: tb/tb_multi_button_ctrl.sv
// Bench for multi_button_ctrl: directed segments, corner sequences, random.
// Long-press expectations follow BTN_LONG_PRESS_EN.
module tb_multi_button_ctrl;

  localparam int N = 4;
  localparam int D = 4;
  localparam int L = 20;
`ifdef BTN_LONG_PRESS_EN
  localparam bit LONG_ON = 1'b1;
`else
  localparam bit LONG_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] btn = '0;
  logic [N-1:0] lvl, prs, rls, lng;
  logic [N-1:0] btn_n = '1;
  logic [N-1:0] lvl_n, prs_n, rls_n, lng_n;

  always #5 clk = ~clk;

  multi_button_ctrl #(
    .NUM_BTN(N), .PUSHED_LVL(1'b1),
    .DEBOUNCE_CYC(D), .LONG_CYC(L), .CNT_W(32)
  ) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_button(btn), .o_level(lvl),
    .o_press(prs), .o_release(rls),
    .o_long(lng)
  );

  multi_button_ctrl #(
    .NUM_BTN(N), .PUSHED_LVL(1'b0),
    .DEBOUNCE_CYC(D), .LONG_CYC(L), .CNT_W(32)
  ) dut_n (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_button(btn_n), .o_level(lvl_n),
    .o_press(prs_n), .o_release(rls_n),
    .o_long(lng_n)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name,
                       input logic [15:0] got,
                       input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Reference: a change is accepted after D consecutive synced samples
  // disagreeing with the current level; samples lag raw by 2 edges.
  bit           d1 [N];
  bit           d2 [N];
  int           mis [N];
  int           hold [N];
  bit           ldone [N];
  logic [N-1:0] m_lvl, e_prs, e_rls, e_lng;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      d1[i] = 1'b0; d2[i] = 1'b0;
      mis[i] = 0; hold[i] = 0; ldone[i] = 1'b0;
    end
    m_lvl = '0; e_prs = '0; e_rls = '0; e_lng = '0;
  endtask

  task automatic model_edge(input logic [N-1:0] raw);
    e_prs = '0; e_rls = '0; e_lng = '0;
    for (int i = 0; i < N; i++) begin
      bit smp;
      smp = d2[i];
      d2[i] = d1[i];
      d1[i] = raw[i];
      if (smp != m_lvl[i]) begin
        mis[i]++;
        if (mis[i] == D) begin
          m_lvl[i] = smp;
          mis[i] = 0;
          hold[i] = 0;
          if (smp) begin
            e_prs[i] = 1'b1;
            ldone[i] = 1'b0;
          end else begin
            e_rls[i] = 1'b1;
          end
        end
      end else if (mis[i] != 0) begin
        mis[i] = 0;
        hold[i] = 0;
      end else if (m_lvl[i]) begin
        if (hold[i] < L) hold[i]++;
        if (hold[i] == L && !ldone[i]) begin
          ldone[i] = 1'b1;
          e_lng[i] = LONG_ON;
        end
      end
    end
  endtask

  int tp, tr, tl;

  task automatic step();
    logic [N-1:0] raw;
    raw = btn;
    @(posedge clk);
    model_edge(raw);
    #1;
    check("cycle_out", {lvl, prs, rls, lng},
          {m_lvl, e_prs, e_rls, e_lng});
    check("inv_idle", {lvl_n, prs_n, rls_n, lng_n}, 16'h0);
    tp += $countones(prs);
    tr += $countones(rls);
    tl += $countones(lng);
  endtask

  typedef struct {
    logic [N-1:0] btn;
    int           cyc;
    logic [N-1:0] lvl;
    int           np;
    int           nr;
    int           nl;
  } seg_t;

  seg_t segs [20];
  int   nseg;
  int   n;

  task automatic add(input logic [N-1:0] b, input int c,
                     input logic [N-1:0] lv, input int np,
                     input int nr, input int nl);
    segs[nseg] = '{b, c, lv, np, nr, nl};
    nseg++;
  endtask

  initial begin
    model_reset();
    nseg = 0;
    add(4'b0000,  3, 4'b0000, 0, 0, 0);
    add(4'b0001, 10, 4'b0001, 1, 0, 0);
    add(4'b0000, 10, 4'b0000, 0, 1, 0);
    add(4'b0010,  2, 4'b0000, 0, 0, 0);
    add(4'b0000,  1, 4'b0000, 0, 0, 0);
    add(4'b0010,  6, 4'b0010, 1, 0, 0);
    add(4'b0000,  8, 4'b0000, 0, 1, 0);
    add(4'b0100,  8, 4'b0100, 1, 0, 0);
    add(4'b0000,  2, 4'b0100, 0, 0, 0);
    add(4'b0100,  8, 4'b0100, 0, 0, 0);
    add(4'b0000,  8, 4'b0000, 0, 1, 0);
    add(4'b1000, 40, 4'b1000, 1, 0, LONG_ON ? 1 : 0);
    add(4'b0000,  8, 4'b0000, 0, 1, 0);
    add(4'b1001,  8, 4'b1001, 2, 0, 0);
    add(4'b0000,  8, 4'b0000, 0, 2, 0);

    repeat (2) @(negedge clk);
    check("reset_state", {lvl, prs, rls, lng}, 16'h0);
    check("reset_inv", {lvl_n, prs_n, rls_n, lng_n}, 16'h0);
    rst_n = 1'b1;

    for (int s = 0; s < nseg; s++) begin
      btn = segs[s].btn;
      tp = 0; tr = 0; tl = 0;
      repeat (segs[s].cyc) step();
      check($sformatf("seg%0d_lvl", s), 16'(lvl), 16'(segs[s].lvl));
      check($sformatf("seg%0d_press", s), 16'(tp), 16'(segs[s].np));
      check($sformatf("seg%0d_rel", s), 16'(tr), 16'(segs[s].nr));
      check($sformatf("seg%0d_long", s), 16'(tl), 16'(segs[s].nl));
    end

    // Exact accept latency, both edges.
    btn = 4'b0001;
    n = 0;
    do begin step(); n++; end while (!prs[0] && n < 20);
    check("press_latency", 16'(n), 16'd6);
    repeat (4) step();
    btn = 4'b0000;
    n = 0;
    do begin step(); n++; end while (!rls[0] && n < 20);
    check("rel_latency", 16'(n), 16'd6);
    repeat (3) step();

    // Reset while held, button kept down through reset release.
    btn = 4'b0100;
    repeat (10) step();
    check("held_before_rst", 16'(lvl), 16'h4);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async", {lvl, prs, rls, lng}, 16'h0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold", {lvl, prs, rls, lng}, 16'h0);
    @(negedge clk) rst_n = 1'b1;
    model_reset();
    n = 0;
    do begin step(); n++; end while (!prs[2] && n < 20);
    check("press_after_rst", 16'(n), 16'd6);

    // Reset while held, released during reset: no release pulse.
    repeat (3) step();
    #2 rst_n = 1'b0;
    btn = 4'b0000;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tp = 0; tr = 0; tl = 0;
    repeat (12) step();
    check("no_rel_after_rst", 16'(tr), 16'd0);

    // Random: fast toggling for bounces, then slow for long holds.
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < N; i++) begin
        if (k < 1500) begin
          if ($urandom_range(0, 2) == 0) btn[i] = ~btn[i];
        end else begin
          if ($urandom_range(0, 39) == 0) btn[i] = ~btn[i];
        end
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
